tictactoe_board_writer: RTL and testbench

//  Input side of the tic-tac-toe board. Scans a 4x3 key matrix and debounces it.

---
 rtl/tictactoe_pkg.sv | 52 +++++
 rtl/keypad_scanner.sv | 154 +++++++++++++++
 rtl/tictactoe_board_writer.sv | 112 +++++++++++
 tb/tb_tictactoe_board_writer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tictactoe_pkg                                                              |
// | Shared cell encoding, key codes and win-line table for the board blocks.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    X     = 2'd1,
    O     = 2'd2
  } cell_t;

  localparam int NUM_CELLS = 9;
  localparam int BOARD_W   = 18;

  // Digits 1..9 map to themselves; the remaining codes sit above the digit range.
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_ZERO = 4'd11;
  localparam logic [3:0] KEY_HASH = 4'd12;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef logic [3:0] cell_idx_t;

  localparam cell_idx_t WIN_LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [3:0] key_of(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = KEY_ZERO;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_scanner                                                             |
// | Drives the 4x3 key matrix columns, decodes one key per scan, debounces.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module keypad_scanner #(
  parameter int SCAN_DIV       = 12500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] key_col,
  input  logic [3:0] key_row,
  output logic       key_valid,
  output logic [3:0] key_code
);
  import tictactoe_pkg::*;

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);
  localparam logic [CNT_W-1:0] c_deb      = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_COMMIT  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_col;
  logic [1:0]       r_nkeys;
  logic [3:0]       r_acc_code;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_key;

  logic [1:0]       w_col_idx;
  logic [2:0]       w_row_n;
  logic [2:0]       w_total;
  logic [3:0]       w_row_code;
  logic [3:0]       w_this_code;
  logic [3:0]       w_scan_code;
  logic             w_sample;
  logic             w_scan_done;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       w_key_nxt;

  assign w_col_idx = r_col[2] ? 2'd2 : (r_col[1] ? 2'd1 : 2'd0);
  assign w_row_n   = {2'b00, key_row[0]} + {2'b00, key_row[1]}
                   + {2'b00, key_row[2]} + {2'b00, key_row[3]};
  assign w_total   = {1'b0, r_nkeys} + w_row_n;
  assign w_sample  = (r_div == c_div_last);
  assign w_scan_done = w_sample && r_col[2];
  assign w_cnt_inc = r_cnt + c_cnt_one;

  always_comb begin
    w_row_code = KEY_NONE;
    for (int r = 0; r < 4; r++) begin
      if (key_row[r]) w_row_code = key_of(2'(r), w_col_idx);
    end
  end

  // Exactly one key across the whole scan: it came from an earlier column or this one.
  assign w_this_code = (r_nkeys == 2'd1) ? r_acc_code : w_row_code;
  assign w_scan_code = (w_total == 3'd1) ? w_this_code : KEY_NONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div      <= '0;
      r_col      <= 3'b001;
      r_nkeys    <= 2'd0;
      r_acc_code <= KEY_NONE;
    end else if (w_sample) begin
      r_div <= '0;
      r_col <= {r_col[1:0], r_col[2]};
      if (r_col[2]) begin
        r_nkeys    <= 2'd0;
        r_acc_code <= KEY_NONE;
      end else begin
        r_nkeys    <= (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
        r_acc_code <= (w_total == 3'd1) ? w_this_code : r_acc_code;
      end
    end else begin
      r_div <= r_div + c_div_one;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_key   <= KEY_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_key_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_key_nxt   = r_key;
    case (r_state)
      S_IDLE: begin
        if (w_scan_done && (w_scan_code != KEY_NONE)) begin
          w_state_nxt = (c_deb == c_cnt_one) ? S_COMMIT : S_PRESS;
          w_cnt_nxt   = c_cnt_one;
          w_key_nxt   = w_scan_code;
        end
      end
      S_PRESS: begin
        if (w_scan_done) begin
          if (w_scan_code == r_key) begin
            if (w_cnt_inc == c_deb) w_state_nxt = S_COMMIT;
            else                    w_cnt_nxt   = w_cnt_inc;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_COMMIT: begin
        w_state_nxt = S_RELEASE;
        w_cnt_nxt   = '0;
      end
      default: begin
        if (w_scan_done) begin
          if (w_scan_code != KEY_NONE) begin
            w_cnt_nxt = '0;
          end else if (w_cnt_inc == c_deb) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
    endcase
  end

  assign key_col   = r_col;
  assign key_valid = (r_state == S_COMMIT);
  assign key_code  = r_key;

endmodule
`default_nettype wire

// File: rtl/tictactoe_board_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tictactoe_board_writer                                                     |
// | Keypad-driven board register, turn tracking, illegal-move and win/draw.    |
// | Define WIN_DETECT_EN to include three-in-a-row detection.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tictactoe_board_writer #(
  parameter int SCAN_DIV       = 12500,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  key_col,
  input  logic [3:0]  key_row,
  output logic [17:0] board_flat,
  output logic        turn,
  output logic        move_strobe,
  output logic        illegal,
  output logic        game_over,
  output logic [1:0]  winner
);
  import tictactoe_pkg::*;

  cell_t      r_board [NUM_CELLS];
  logic [3:0] r_move_cnt;

  logic       w_key_valid;
  logic [3:0] w_key_code;
  logic       w_is_digit;
  logic [3:0] w_idx;
  logic       w_cell_free;
  cell_t      w_win_mark;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk       (clk),
    .rst       (rst),
    .key_col   (key_col),
    .key_row   (key_row),
    .key_valid (w_key_valid),
    .key_code  (w_key_code)
  );

  assign w_is_digit  = (w_key_code >= 4'd1) && (w_key_code <= 4'd9);
  assign w_idx       = w_is_digit ? (w_key_code - 4'd1) : 4'd0;
  assign w_cell_free = (r_board[w_idx] == EMPTY);

`ifdef WIN_DETECT_EN
  always_comb begin
    w_win_mark = EMPTY;
    for (int l = 0; l < 8; l++) begin
      if ((r_board[WIN_LINES[l][0]] != EMPTY) &&
          (r_board[WIN_LINES[l][0]] == r_board[WIN_LINES[l][1]]) &&
          (r_board[WIN_LINES[l][0]] == r_board[WIN_LINES[l][2]]))
        w_win_mark = r_board[WIN_LINES[l][0]];
    end
  end
`else
  assign w_win_mark = EMPTY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CELLS; i++) r_board[i] <= EMPTY;
      turn        <= 1'b0;
      r_move_cnt  <= 4'd0;
      move_strobe <= 1'b0;
      illegal     <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 2'd0;
    end else begin
      move_strobe <= 1'b0;
      illegal     <= 1'b0;
      if (w_key_valid) begin
        if (w_is_digit) begin
          if (!game_over && w_cell_free) begin
            r_board[w_idx] <= turn ? O : X;
            turn           <= ~turn;
            r_move_cnt     <= (r_move_cnt == 4'd9) ? 4'd9 : r_move_cnt + 4'd1;
            move_strobe    <= 1'b1;
          end else begin
            illegal <= 1'b1;
          end
        end else if (w_key_code == KEY_HASH) begin
          for (int i = 0; i < NUM_CELLS; i++) r_board[i] <= EMPTY;
          turn       <= 1'b0;
          r_move_cnt <= 4'd0;
          game_over  <= 1'b0;
          winner     <= 2'd0;
        end
      end else if (move_strobe) begin
        // The board already holds the new mark while the strobe is high.
        if (w_win_mark != EMPTY) begin
          game_over <= 1'b1;
          winner    <= w_win_mark;
        end else if (r_move_cnt == 4'd9) begin
          game_over <= 1'b1;
          winner    <= 2'd0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_flat
    assign board_flat[2*i+1:2*i] = r_board[i];
  end

endmodule
`default_nettype wire

// File: tb/tb_tictactoe_board_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tictactoe_board_writer                                                  |
// | Randomised keypad stimulus with a rule-level game model and scoreboard.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tictactoe_board_writer;

  localparam int SCAN = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  key_col;
  logic [3:0]  key_row;
  logic [17:0] board_flat;
  logic        turn;
  logic        move_strobe;
  logic        illegal;
  logic        game_over;
  logic [1:0]  winner;

  logic [2:0] keys [4];

  typedef struct {
    bit          is_move;
    logic [17:0] board;
    bit          turn;
    bit          go;
    logic [1:0]  win;
  } exp_t;

  exp_t q[$];
  int   n_checks;
  int   n_pass;

  int mb [9];
  int mturn;
  int mcnt;
  bit mgo;
  int mwin;
  int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  tictactoe_board_writer #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_col     (key_col),
    .key_row     (key_row),
    .board_flat  (board_flat),
    .turn        (turn),
    .move_strobe (move_strobe),
    .illegal     (illegal),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) key_row[r] = |(keys[r] & key_col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [17:0] mflat();
    logic [17:0] f;
    for (int i = 0; i < 9; i++) f[2*i +: 2] = 2'(mb[i]);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) mb[i] = 0;
    mturn = 0; mcnt = 0; mgo = 0; mwin = 0;
  endtask

  // k: 1..9 digits, 10 '*', 11 '0', 12 '#'
  task automatic model_key(input int k);
    exp_t e;
    if (k >= 1 && k <= 9) begin
      if (!mgo && mb[k-1] == 0) begin
        mb[k-1] = mturn + 1;
        mturn   = 1 - mturn;
        if (mcnt < 9) mcnt++;
        e.is_move = 1;
`ifdef WIN_DETECT_EN
        for (int l = 0; l < 8; l++)
          if (mb[lines[l][0]-1] != 0 && mb[lines[l][0]-1] == mb[lines[l][1]-1] &&
              mb[lines[l][0]-1] == mb[lines[l][2]-1]) mwin = mb[lines[l][0]-1];
        if (mwin != 0) mgo = 1;
`endif
        if (!mgo && mcnt == 9) mgo = 1;
      end else begin
        e.is_move = 0;
      end
      e.board = mflat(); e.turn = mturn[0]; e.go = mgo; e.win = 2'(mwin);
      q.push_back(e);
    end else if (k == 12) begin
      model_reset();
    end
  endtask

  task automatic set_key(input int k, input logic v);
    int r, c;
    if (k <= 9) begin r = (k - 1) / 3; c = (k - 1) % 3; end
    else begin r = 3; c = k - 10; end
    keys[r][c] = v;
  endtask

  task automatic press(input int k, input int hold_clks);
    set_key(k, 1'b1);
    repeat (hold_clks) @(negedge clk);
    set_key(k, 1'b0);
    repeat (4*SCAN) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_board"}, board_flat, mflat());
    check({tag, "_turn"}, turn, mturn[0]);
    check({tag, "_game_over"}, game_over, mgo);
    check({tag, "_winner"}, winner, 2'(mwin));
  endtask

  task automatic play(input int k);
    model_key(k);
    press(k, 4*SCAN);
    check("pending_events", q.size(), 0);
    if (k >= 10) check_state("nonmove");
  endtask

  // Scoreboard monitor: consumes one expected event per DUT pulse.
  initial begin
    exp_t e, pe;
    bit   pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          check("post_move_game_over", game_over, pe.go);
          check("post_move_winner", winner, pe.win);
          pend = 0;
        end
        if (move_strobe || illegal) begin
          if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_pulse: move_strobe=%0b illegal=%0b, expected no pulse",
                     move_strobe, illegal);
          end else begin
            e = q.pop_front();
            check("pulse_kind", {move_strobe, illegal}, e.is_move ? 2'b10 : 2'b01);
            check("pulse_board", board_flat, e.board);
            check("pulse_turn", turn, e.turn);
            if (e.is_move) begin pe = e; pend = 1; end
            else check("illegal_game_over_hold", game_over, e.go);
          end
        end
      end
    end
  end

  initial begin
    int seq_win  [5] = '{1, 4, 2, 5, 3};
    int seq_draw [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    int guard;
    n_checks = 0; n_pass = 0;
    for (int r = 0; r < 4; r++) keys[r] = 3'b000;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_key_col", key_col, 3'b001);
    check_state("rst");
    check("rst_pulses", {move_strobe, illegal}, 2'b00);

    rst = 1'b0;
    #1 check("col_t0", key_col, 3'b001);
    repeat (4) @(negedge clk); check("col_t4", key_col, 3'b010);
    repeat (4) @(negedge clk); check("col_t8", key_col, 3'b100);
    repeat (4) @(negedge clk); check("col_t12", key_col, 3'b001);

    // Long hold commits once, repeat press on the same cell is rejected
    model_key(5); press(5, 10*SCAN);
    check("pending_events", q.size(), 0);
    check_state("hold5");
    play(5);
    check_state("repeat5");

    play(12);
    foreach (seq_win[i]) play(seq_win[i]);
    check_state("win_seq");
    play(9);

    play(12);
    foreach (seq_draw[i]) play(seq_draw[i]);
    check_state("draw_seq");
    play(12);

    // Short tap and two simultaneous keys must not commit
    press(7, 8);
    check_state("short_tap");
    keys[0] = 3'b011;
    repeat (4*SCAN) @(negedge clk);
    keys[0] = 3'b000;
    repeat (4*SCAN) @(negedge clk);
    check_state("two_keys");

    // Reset while a key sits in the debounce window
    guard = 0;
    while (key_col != 3'b100 && guard < 40) begin @(negedge clk); guard++; end
    while (key_col != 3'b001 && guard < 40) begin @(negedge clk); guard++; end
    check("col_sync_timeout", guard < 40, 1'b1);
    set_key(3, 1'b1);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    set_key(3, 1'b0);
    repeat (6*SCAN) @(negedge clk);
    check("rst_press_events", q.size(), 0);
    check_state("rst_press");

    // Random games
    play(12);
    for (int n = 0; n < 45; n++) begin
      int k;
      if ($urandom_range(0, 99) < 85) k = int'($urandom_range(1, 9));
      else                            k = int'($urandom_range(10, 12));
      play(k);
    end
    check_state("random_end");

    repeat (5) @(negedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
